// File: rtl/seq_det_sched.sv
// Four-channel 1101 sequence detector sharing one next-state function via a round-robin grant.
// Optional per-channel context clear enabled by defining SEQ_DET_SCHED_CLR_EN.
module seq_det_sched (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] din,
`ifdef SEQ_DET_SCHED_CLR_EN
  input  logic [3:0] ctx_clr,
`endif
  output logic [3:0] gnt,
  output logic       hit,
  output logic [1:0] hit_id
);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_e;

  state_e     ctx_q [4];
  state_e     ctx_d [4];
  logic [1:0] ptr_q, ptr_d;
  logic       hit_q, hit_d;
  logic [1:0] hit_id_q, hit_id_d;

  logic [1:0] win;
  logic [1:0] idx;
  logic       any;
  logic       bit_in;
  state_e     cur;
  state_e     nxt;
  logic       match;
  logic [3:0] clr;

`ifdef SEQ_DET_SCHED_CLR_EN
  assign clr = ctx_clr;
`else
  assign clr = 4'b0000;
`endif

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win = 2'd0;
    any = 1'b0;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    gnt = any ? (4'b0001 << win) : 4'b0000;
  end

  // The single detector transition, applied to whichever channel won.
  always_comb begin
    cur    = ctx_q[win];
    bit_in = din[win];
    nxt    = S0;
    match  = 1'b0;
    case (cur)
      S0: nxt = bit_in ? S1 : S0;
      S1: nxt = bit_in ? S2 : S0;
      S2: nxt = bit_in ? S2 : S3;
      S3: begin
        nxt   = bit_in ? S1 : S0;
        match = bit_in;
      end
      default: nxt = S0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ctx_d[i] = ctx_q[i];
    end
    ptr_d    = ptr_q;
    hit_d    = 1'b0;
    hit_id_d = hit_id_q;
    if (any) begin
      ctx_d[win] = nxt;
      ptr_d      = win + 2'd1;
      hit_d      = match && !clr[win];
      if (hit_d) begin
        hit_id_d = win;
      end
    end
    // A clear wins over the update of the same channel.
    for (int i = 0; i < 4; i++) begin
      if (clr[i]) begin
        ctx_d[i] = S0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        ctx_q[i] <= S0;
      end
      ptr_q    <= 2'd0;
      hit_q    <= 1'b0;
      hit_id_q <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        ctx_q[i] <= ctx_d[i];
      end
      ptr_q    <= ptr_d;
      hit_q    <= hit_d;
      hit_id_q <= hit_id_d;
    end
  end

  assign hit    = hit_q;
  assign hit_id = hit_id_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: directed scenarios plus constrained-random traffic
// compared against a per-channel bit-history model.
module tb_seq_det_sched;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] din   = 4'b0000;
  logic [3:0] gnt;
  logic       hit;
  logic [1:0] hit_id;
`ifdef SEQ_DET_SCHED_CLR_EN
  logic [3:0] ctx_clr = 4'b0000;
`endif
  logic [3:0] clr_v = 4'b0000;

  int checks   = 0;
  int failures = 0;

  // Model: last four granted bits per channel since reset/clear.
  logic [3:0] hist [4];
  int         mptr;
  int         last_w;
  logic [3:0] obs_gnt;
  int         dut_hits;
  int         hit_ids[$];
  int         h0;

  seq_det_sched dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .din    (din),
`ifdef SEQ_DET_SCHED_CLR_EN
    .ctx_clr(ctx_clr),
`endif
    .gnt    (gnt),
    .hit    (hit),
    .hit_id (hit_id)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req   = 4'b0001;
    din   = 4'b1111;
    clr_v = 4'b0000;
`ifdef SEQ_DET_SCHED_CLR_EN
    ctx_clr = 4'b0000;
`endif
    #1;
    chk("rst_gnt", {4'b0, gnt}, 8'h01);
    chk("rst_hit", {7'b0, hit}, 8'h00);
    chk("rst_hit_id", {6'b0, hit_id}, 8'h00);
    @(posedge clock);
    #1;
    chk("rst_hold_hit", {7'b0, hit}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) hist[i] = 4'b0000;
    mptr = 0;
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d);
    logic [3:0] exp_g;
    logic       found;
    logic       e_hit;
    int         w;
    @(negedge clock);
    req = r;
    din = d;
`ifdef SEQ_DET_SCHED_CLR_EN
    ctx_clr = clr_v;
`endif
    #1;
    exp_g = 4'b0000;
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && r[(mptr + k) % 4]) begin
        found = 1'b1;
        w     = (mptr + k) % 4;
      end
    end
    if (found) exp_g[w] = 1'b1;
    obs_gnt = gnt;
    chk("gnt", {4'b0, gnt}, {4'b0, exp_g});
    e_hit = 1'b0;
    if (found) begin
      hist[w] = {hist[w][2:0], d[w]};
      e_hit   = (hist[w] == 4'b1101);
      mptr    = (w + 1) % 4;
      last_w  = w;
    end
`ifdef SEQ_DET_SCHED_CLR_EN
    for (int i = 0; i < 4; i++) begin
      if (clr_v[i]) begin
        hist[i] = 4'b0000;
        if (found && i == w) e_hit = 1'b0;
      end
    end
`endif
    @(posedge clock);
    #1;
    chk("hit", {7'b0, hit}, {7'b0, e_hit});
    if (e_hit) chk("hit_id", {6'b0, hit_id}, 8'(w));
    if (hit === 1'b1) begin
      dut_hits++;
      hit_ids.push_back(int'(hit_id));
    end
  endtask

  task automatic feed1(input int ch, input logic [7:0] bits, input int n);
    logic b;
    for (int j = n - 1; j >= 0; j--) begin
      b = bits[j];
      step(4'b0001 << ch, {4{b}});
    end
  endtask

  initial begin
    logic [3:0] pend;
    logic [3:0] pdin;
    logic [3:0] s1;
    logic [3:0] s2;
    int         n1;
    int         n2;
    logic [3:0] r;
    logic [3:0] d;
    dut_hits = 0;
    mptr     = 0;
    last_w   = 0;
    for (int i = 0; i < 4; i++) hist[i] = 4'b0000;

    do_reset();

    // Single channel stream with overlapping matches, granted every cycle.
    h0 = dut_hits;
    feed1(0, 8'b0110_1101, 7);
    chk("overlap_hits", 8'(dut_hits - h0), 8'd2);

    // Full rotation with all four requesting.
    do_reset();
    step(4'b1111, 4'b0000); chk("rr_all0", {4'b0, obs_gnt}, 8'h01);
    step(4'b1111, 4'b0000); chk("rr_all1", {4'b0, obs_gnt}, 8'h02);
    step(4'b1111, 4'b0000); chk("rr_all2", {4'b0, obs_gnt}, 8'h04);
    step(4'b1111, 4'b0000); chk("rr_all3", {4'b0, obs_gnt}, 8'h08);
    step(4'b1111, 4'b0000); chk("rr_all4", {4'b0, obs_gnt}, 8'h01);

    // Two requesters alternate; an idle cycle leaves the pointer alone.
    do_reset();
    step(4'b1010, 4'b0000); chk("rr_1010_0", {4'b0, obs_gnt}, 8'h02);
    step(4'b1010, 4'b0000); chk("rr_1010_1", {4'b0, obs_gnt}, 8'h08);
    step(4'b1010, 4'b0000); chk("rr_1010_2", {4'b0, obs_gnt}, 8'h02);
    step(4'b0000, 4'b0000); chk("idle_gnt", {4'b0, obs_gnt}, 8'h00);
    step(4'b1010, 4'b0000); chk("rr_1010_3", {4'b0, obs_gnt}, 8'h08);

    // Channels 1 and 2 interleave 1101, each bit held until granted.
    do_reset();
    h0 = dut_hits;
    hit_ids.delete();
    s1 = 4'b1101; s2 = 4'b1101; n1 = 4; n2 = 4;
    while (n1 > 0 || n2 > 0) begin
      r = {1'b0, n2 > 0, n1 > 0, 1'b0};
      d = 4'b0000;
      if (n1 > 0) d[1] = s1[n1-1];
      if (n2 > 0) d[2] = s2[n2-1];
      step(r, d);
      if (last_w == 1) n1--; else n2--;
    end
    chk("ilv_hits", 8'(dut_hits - h0), 8'd2);
    if (hit_ids.size() == 2) begin
      chk("ilv_id0", 8'(hit_ids[0]), 8'd1);
      chk("ilv_id1", 8'(hit_ids[1]), 8'd2);
    end

    // Reset mid-pattern discards the partial match.
    do_reset();
    h0 = dut_hits;
    hit_ids.delete();
    feed1(3, 8'b0000_0110, 3);
    do_reset();
    feed1(3, 8'b0000_0001, 1);
    chk("rst_discard", 8'(dut_hits - h0), 8'd0);
    feed1(3, 8'b0000_1101, 4);
    chk("post_rst_hits", 8'(dut_hits - h0), 8'd1);
    if (hit_ids.size() == 1) chk("post_rst_id", 8'(hit_ids[0]), 8'd3);

    // Context clear beating a completing bit.
    do_reset();
    h0 = dut_hits;
`ifdef SEQ_DET_SCHED_CLR_EN
    feed1(0, 8'b0000_0110, 3);
    clr_v = 4'b0001;
    step(4'b0001, 4'b1111);
    clr_v = 4'b0000;
    chk("clr_gnt", {4'b0, obs_gnt}, 8'h01);
    feed1(0, 8'b0000_0101, 3);
    chk("clr_no_hit", 8'(dut_hits - h0), 8'd0);
`else
    feed1(0, 8'b0000_1101, 4);
    chk("noclr_hit", 8'(dut_hits - h0), 8'd1);
`endif

    // Random traffic honouring the hold-until-granted rule.
    do_reset();
    pend = 4'b0000;
    pdin = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
        pend = 4'b0000;
      end
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pdin[i] = 1'($urandom_range(0, 3) != 0);
        end
      end
`ifdef SEQ_DET_SCHED_CLR_EN
      clr_v = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
`endif
      r = pend;
      step(pend, pdin);
      if (r != 4'b0000) pend[last_w] = 1'b0;
    end
    clr_v = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001: No parameters; channel count fixed at 4, detected pattern fixed at 1101 (first bit oldest), overlapping matches allowed.
REQ-002: clock  input  1  sole clock; all state updates on rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: req  input  4  per-channel request; req[i]=1 means din[i] holds a valid serial bit this cycle.
REQ-005: din  input  4  per-channel serial data bit; din[i] is meaningful only while req[i]=1.
REQ-006: gnt  output  4  one-hot (or zero) grant, combinational from req and priority pointer; gnt[i]=1 means din[i] is consumed at the coming edge.
REQ-007: hit  output  1  registered; 1 for exactly one cycle after the granted bit completes 1101 on its channel.
REQ-008: hit_id  output  2  registered; channel index of the match, valid while hit=1.

Function
REQ-009: The block SHALL hold four 2-bit context registers ctx[0..3], each the detector state of one channel: S0=none, S1="1", S2="11", S3="110".
REQ-010: Transitions for bit b: S0: b=1->S1, b=0->S0; S1: 1->S2, 0->S0; S2: 1->S2, 0->S3; S3: 1->S1 with match, 0->S0.
REQ-011: One shared next-state/match function SHALL serve all channels; each cycle at most one channel is advanced.
REQ-012: Arbitration: round-robin with 2-bit pointer ptr; the winner is the first i with req[i]=1 searching ptr, ptr+1, ... modulo 4.
REQ-013: gnt SHALL be 0000 when req=0000; gnt SHALL never have more than one bit set.
REQ-014: On a grant to channel w, at the edge: ctx[w] <= next state of (ctx[w], din[w]); ptr <= w+1 modulo 4 (3 wraps to 0).
REQ-015: With no request, ptr and all ctx SHALL hold.
REQ-016: Ungranted channels' contexts SHALL hold; a requester that is not granted SHALL keep req and din stable until granted (bit is not lost or duplicated).
REQ-017: Latency: match bit granted in cycle t -> hit=1, hit_id=w in cycle t+1; hit SHALL be 0 in any cycle following a cycle without a match.
REQ-018: Interleaving SHALL be transparent: the per-channel match sequence equals that of an independent detector fed only that channel's granted bits.
REQ-019: A single requester held continuously SHALL be granted every cycle (full throughput).

Reset
REQ-020: While reset=1: all ctx=S0, ptr=0, hit=0, hit_id=00; gnt follows REQ-012 combinationally but no state updates.
REQ-021: Reset asserted mid-stream SHALL discard all partial matches; the first post-reset match requires a full 1101 on that channel.

Configuration
REQ-022: Macro SEQ_DET_SCHED_CLR_EN: when defined, an extra input port ctx_clr (4 bits) exists; ctx_clr[i]=1 forces ctx[i] to S0 at the next edge.
REQ-023: With SEQ_DET_SCHED_CLR_EN, clear beats update: if channel i is granted while ctx_clr[i]=1, the grant and ptr advance still occur, the bit is discarded, ctx[i]=S0, and no hit is produced.
REQ-024: Without SEQ_DET_SCHED_CLR_EN, ctx_clr does not exist and contexts are cleared only by reset.

Verification
REQ-025: Reset, then req=0001, din[0] stream 1,1,0,1,1,0,1 -> hit=1, hit_id=00 in cycles 5 and 8 (overlap match), hit=0 elsewhere.
REQ-026: req=1111 held 4 cycles from ptr=0 -> gnt 0001,0010,0100,1000 in order, then 0001 again.
REQ-027: req=1010 held, ptr=0 -> gnt 0010 then 1000 alternately; req=0000 -> gnt=0000, ptr and contexts unchanged.
REQ-028: Channels 1 and 2 both stream 1101 interleaved (each bit held until granted) -> exactly two hits, hit_id=01 then 10, no cross-channel match.
REQ-029: Channel 3 fed 1,1,0 then reset pulse, then 1 -> no hit; subsequent 1,1,0,1 -> hit=1, hit_id=11.
REQ-030: With SEQ_DET_SCHED_CLR_EN: channel 0 fed 1,1,0, then final 1 granted with ctx_clr=0001 -> no hit, ctx[0]=S0; without macro same stream (no clear) -> hit, hit_id=00.
